conv_layer_sequencer: RTL and testbench

- Drives the control/data inputs (function_sel, data_input, layer_reset) of one computation_subunit for one convolution layer.
- Latches a layer configuration on start and issues the fixed command sequence: configuration fetch, layer reset, filter-weight load, neuron preload, streaming, then drain.
- Takes weights and neurons from an upstream valid/ready byte stream and inserts NO_FUNCTION bubbles when that stream stalls.

---
 rtl/conv_layer_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Command sequencer for one computation_subunit convolution layer: config fetch,
// layer reset, weight load, neuron preload, streaming and drain, fed by a valid/ready byte stream.
module conv_layer_sequencer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_filter_width,
    input  logic [DATA_W-1:0] cfg_filter_size,
    input  logic [DATA_W-1:0] cfg_pic_width,
    input  logic [DATA_W-1:0] cfg_pic_height,
    input  logic [DATA_W-1:0] cfg_num_filters,
    input  logic [LEN_W-1:0]  cfg_stream_len,
    input  logic [DATA_W-1:0] cfg_drain_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        function_sel,
    output logic [DATA_W-1:0] data_input,
    output logic              layer_reset,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [3:0]        dbg_state
);

    localparam logic [3:0] F_NOP      = 4'd0;
    localparam logic [3:0] F_FW       = 4'd1;
    localparam logic [3:0] F_FS       = 4'd2;
    localparam logic [3:0] F_PW       = 4'd3;
    localparam logic [3:0] F_PH       = 4'd4;
    localparam logic [3:0] F_NF       = 4'd5;
    localparam logic [3:0] F_WEIGHT   = 4'd6;
    localparam logic [3:0] F_NEURON   = 4'd8;
    localparam logic [3:0] F_NEUR_OP  = 4'd9;
    localparam logic [3:0] F_OPERAND  = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LRST, S_GAP1, S_WEIGHT, S_GAP2,
        S_PRELOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_fw, r_fs, r_pw, r_ph, r_nf, r_drain;
    logic [LEN_W-1:0]  r_slen;

    logic              w_cfg_bad;
    logic              w_xfer;
    logic [LEN_W-1:0]  w_weight_last;
    logic [LEN_W-1:0]  w_preload_last;
    logic [LEN_W-1:0]  w_stream_last;
    logic [LEN_W-1:0]  w_drain_last;

    assign w_cfg_bad = (cfg_filter_width == '0) || (cfg_filter_size == '0) ||
                       (cfg_num_filters == '0) ||
                       (cfg_stream_len <= LEN_W'(cfg_filter_width));
    assign w_xfer         = in_valid && in_ready;
    assign w_weight_last  = LEN_W'(r_fs) * LEN_W'(r_nf) - LEN_W'(1);
    assign w_preload_last = LEN_W'(r_fw) - LEN_W'(1);
    assign w_stream_last  = r_slen - LEN_W'(r_fw) - LEN_W'(1);
    assign w_drain_last   = LEN_W'(r_drain) - LEN_W'(1);
    assign dbg_state      = r_state;

    // Outputs default to a bubble each cycle; a state only overrides what it issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fw         <= '0;
            r_fs         <= '0;
            r_pw         <= '0;
            r_ph         <= '0;
            r_nf         <= '0;
            r_drain      <= '0;
            r_slen       <= '0;
            function_sel <= F_NOP;
            data_input   <= '0;
            layer_reset  <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            function_sel <= F_NOP;
            data_input   <= '0;
            layer_reset  <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            r_fw         <= cfg_filter_width;
                            r_fs         <= cfg_filter_size;
                            r_pw         <= cfg_pic_width;
                            r_ph         <= cfg_pic_height;
                            r_nf         <= cfg_num_filters;
                            r_slen       <= cfg_stream_len;
                            r_drain      <= cfg_drain_len;
                            busy         <= 1'b1;
                            function_sel <= F_FW;
                            data_input   <= cfg_filter_width - DATA_W'(1);
                            r_cnt        <= LEN_W'(1);
                            r_state      <= S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    r_cnt <= r_cnt + LEN_W'(1);
                    case (r_cnt[2:0])
                        3'd1: begin
                            function_sel <= F_FS;
                            data_input   <= r_fs - DATA_W'(1);
                        end
                        3'd2: begin
                            function_sel <= F_PW;
                            data_input   <= r_pw - DATA_W'(1);
                        end
                        3'd3: begin
                            function_sel <= F_PH;
                            data_input   <= r_ph - DATA_W'(1);
                        end
                        default: begin
                            function_sel <= F_NF;
                            data_input   <= r_nf - DATA_W'(1);
                            r_state      <= S_LRST;
                        end
                    endcase
                end
                S_LRST: begin
                    layer_reset <= 1'b1;
                    r_state     <= S_GAP1;
                end
                S_GAP1: begin
                    r_cnt    <= '0;
                    in_ready <= 1'b1;
                    r_state  <= S_WEIGHT;
                end
                S_WEIGHT: begin
                    if (w_xfer) begin
                        function_sel <= F_WEIGHT;
                        data_input   <= in_data;
                        if (r_cnt == w_weight_last) begin
                            in_ready <= 1'b0;
                            r_state  <= S_GAP2;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_GAP2: begin
                    r_cnt    <= '0;
                    in_ready <= 1'b1;
                    r_state  <= S_PRELOAD;
                end
                S_PRELOAD: begin
                    // in_ready stays high into STREAM: stream_len > filter_width guarantees one more byte.
                    if (w_xfer) begin
                        function_sel <= F_NEURON;
                        data_input   <= in_data;
                        if (r_cnt == w_preload_last) begin
                            r_cnt   <= '0;
                            r_state <= S_STREAM;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        function_sel <= F_NEUR_OP;
                        data_input   <= in_data;
                        if (r_cnt == w_stream_last) begin
                            in_ready <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= (r_drain == '0) ? S_DONE : S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    function_sel <= F_OPERAND;
                    if (r_cnt == w_drain_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: an ordered list of expected commands is built from the
// layer configuration and replayed cycle by cycle, inserting bubbles where the source stalls.
module tb_conv_layer_sequencer;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] cfg_filter_width, cfg_filter_size, cfg_pic_width;
    logic [DATA_W-1:0] cfg_pic_height, cfg_num_filters, cfg_drain_len;
    logic [LEN_W-1:0]  cfg_stream_len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        function_sel;
    logic [DATA_W-1:0] data_input;
    logic              layer_reset, busy, done, cfg_err;
    logic [3:0]        dbg_state;

    always #5 clk = ~clk;

    conv_layer_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_filter_width(cfg_filter_width), .cfg_filter_size(cfg_filter_size),
        .cfg_pic_width(cfg_pic_width), .cfg_pic_height(cfg_pic_height),
        .cfg_num_filters(cfg_num_filters), .cfg_stream_len(cfg_stream_len),
        .cfg_drain_len(cfg_drain_len), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .function_sel(function_sel), .data_input(data_input),
        .layer_reset(layer_reset), .busy(busy), .done(done), .cfg_err(cfg_err),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] dat;
        logic       is_lrst;
        logic       is_done;
        logic       xfer;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] src_bytes[$];
    int         checks = 0;
    int         failures = 0;

    logic [7:0]  c_fw, c_fs, c_pw, c_ph, c_nf, c_drain;
    logic [15:0] c_slen;

    function automatic item_t mk(input logic [3:0] sel, input logic [7:0] dat,
                                 input logic lrst, input logic dn, input logic xf);
        item_t it;
        it.sel = sel; it.dat = dat; it.is_lrst = lrst; it.is_done = dn; it.xfer = xf;
        return it;
    endfunction

    task automatic drive_cfg();
        cfg_filter_width = c_fw; cfg_filter_size = c_fs; cfg_pic_width = c_pw;
        cfg_pic_height = c_ph; cfg_num_filters = c_nf; cfg_stream_len = c_slen;
        cfg_drain_len = c_drain;
    endtask

    task automatic set_nominal();
        c_fw = 8'd3; c_fs = 8'd9; c_pw = 8'd5; c_ph = 8'd5; c_nf = 8'd3;
        c_slen = 16'd83; c_drain = 8'd2;
    endtask

    // Command list of one layer; transfer items carry the source byte they must consume.
    task automatic build_items(input bit rand_weights);
        logic [7:0] b;
        exp_q.delete();
        src_bytes.delete();
        exp_q.push_back(mk(4'd1, c_fw - 8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd2, c_fs - 8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd3, c_pw - 8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd4, c_ph - 8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd5, c_nf - 8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd0, 8'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        for (int f = 0; f < int'(c_nf); f++) begin
            for (int w = 0; w < int'(c_fs); w++) begin
                b = rand_weights ? 8'($urandom) : 8'(f + 1);
                src_bytes.push_back(b);
                exp_q.push_back(mk(4'd6, b, 1'b0, 1'b0, 1'b1));
            end
        end
        exp_q.push_back(mk(4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < int'(c_slen); i++) begin
            b = 8'($urandom);
            src_bytes.push_back(b);
            exp_q.push_back(mk((i < int'(c_fw)) ? 4'd8 : 4'd9, b, 1'b0, 1'b0, 1'b1));
        end
        for (int i = 0; i < int'(c_drain); i++)
            exp_q.push_back(mk(4'd10, 8'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    endtask

    // stall_mode: 0 none, 1 every 3rd cycle while a weight/stream byte is due, 2 random.
    task automatic run_seq(input int stall_mode, input int abort_at, input int start_at,
                           output int done_cyc, output int consumed);
        item_t cur, nxt;
        int    ptr, cyc, stalls;
        logic  v, exp_rdy;
        bit    finished, aborted;
        done_cyc = -1; consumed = 0; ptr = 1; cyc = 0; stalls = 0;
        finished = 1'b0; aborted = 1'b0;
        @(negedge clk);
        drive_cfg();
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        cur = exp_q[0];
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            cfg_num_filters = c_nf;
            exp_rdy = (ptr < exp_q.size()) ? exp_q[ptr].xfer : 1'b0;
            checks++;
            if ({function_sel, data_input, layer_reset, done, in_ready, cfg_err} !==
                {cur.sel, cur.dat, cur.is_lrst, cur.is_done, exp_rdy, 1'b0}) begin
                failures++;
                $display("FAIL cycle_%0d sel/data/lrst/done/rdy/err got=%h/%h/%b/%b/%b/%b want=%h/%h/%b/%b/%b/0",
                         cyc, function_sel, data_input, layer_reset, done, in_ready, cfg_err,
                         cur.sel, cur.dat, cur.is_lrst, cur.is_done, exp_rdy);
            end
            if (cur.is_done) begin
                done_cyc = cyc;
                finished = 1'b1;
                in_valid = 1'b0;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_cycle_%0d got=%b want=1", cyc, busy);
                end
                if (abort_at >= 0 && consumed == abort_at) begin
                    reset = 1'b1;
                    in_valid = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    reset = 1'b0;
                    checks++;
                    if ({function_sel, data_input, layer_reset, done, in_ready, busy, cfg_err, dbg_state} !== '0) begin
                        failures++;
                        $display("FAIL abort_outputs got sel=%h data=%h lrst=%b done=%b rdy=%b busy=%b err=%b st=%h want all 0",
                                 function_sel, data_input, layer_reset, done, in_ready, busy, cfg_err, dbg_state);
                    end
                    aborted = 1'b1;
                    finished = 1'b1;
                end else begin
                    v = 1'b1;
                    if (stall_mode == 1) begin
                        if (ptr < exp_q.size() && (cyc % 3 == 0) &&
                            (exp_q[ptr].sel == 4'd6 || exp_q[ptr].sel == 4'd9))
                            v = 1'b0;
                    end else if (stall_mode == 2) begin
                        v = ($urandom_range(0, 3) != 0);
                    end
                    if (start_at == cyc) begin
                        start = 1'b1;
                        cfg_num_filters = 8'd0;
                    end
                    in_valid = v;
                    in_data = (consumed < src_bytes.size()) ? src_bytes[consumed] : 8'($urandom);
                    if (v && in_ready) consumed++;
                    nxt = '0;
                    if (ptr < exp_q.size()) begin
                        if (!exp_q[ptr].xfer || v) begin
                            nxt = exp_q[ptr];
                            ptr++;
                        end else begin
                            stalls++;
                        end
                    end
                    @(posedge clk);
                    cur = nxt;
                end
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout got no done within %0d cycles", cyc);
        end else if (!aborted) begin
            checks++;
            if (done_cyc != exp_q.size() + stalls) begin
                failures++;
                $display("FAIL done_latency got=%0d want=%0d", done_cyc, exp_q.size() + stalls);
            end
            @(negedge clk);
            checks++;
            if ({function_sel, busy, done, in_ready} !== 7'd0) begin
                failures++;
                $display("FAIL post_done got sel=%h busy=%b done=%b rdy=%b want 0", function_sel, busy, done, in_ready);
            end
        end
    endtask

    task automatic check_consumed(input string name, input int got);
        int want;
        want = int'(c_fs) * int'(c_nf) + int'(c_slen);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s_consumed got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        set_nominal();
        drive_cfg();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({function_sel, data_input, layer_reset, done, in_ready, busy, cfg_err, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_state got sel=%h data=%h lrst=%b done=%b rdy=%b busy=%b err=%b want all 0",
                     function_sel, data_input, layer_reset, done, in_ready, busy, cfg_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int dc, cons;
        set_nominal();
        build_items(1'b0);
        run_seq(0, -1, -1, dc, cons);
        checks++;
        if (dc != 121) begin
            failures++;
            $display("FAIL nominal_done_cycle got=%0d want=121", dc);
        end
        check_consumed("nominal", cons);
    endtask

    task automatic test_stall();
        int dc, cons;
        set_nominal();
        build_items(1'b0);
        run_seq(1, -1, -1, dc, cons);
        check_consumed("stall", cons);
    endtask

    task automatic test_cfg_reject();
        for (int k = 0; k < 3; k++) begin
            set_nominal();
            if (k == 0) c_nf = 8'd0;
            else if (k == 1) c_slen = 16'd3;
            else c_fs = 8'd0;
            @(negedge clk);
            drive_cfg();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({cfg_err, busy, function_sel} !== 6'b100000) begin
                failures++;
                $display("FAIL reject_%0d got err=%b busy=%b sel=%h want 1/0/0", k, cfg_err, busy, function_sel);
            end
            @(negedge clk);
            checks++;
            if ({cfg_err, busy, function_sel} !== 6'd0) begin
                failures++;
                $display("FAIL reject_%0d_after got err=%b busy=%b sel=%h want 0/0/0", k, cfg_err, busy, function_sel);
            end
        end
    endtask

    task automatic test_drain_zero();
        int dc, cons;
        set_nominal();
        c_drain = 8'd0;
        build_items(1'b1);
        run_seq(0, -1, -1, dc, cons);
        checks++;
        if (dc != 119) begin
            failures++;
            $display("FAIL drain0_done_cycle got=%0d want=119", dc);
        end
        check_consumed("drain0", cons);
    endtask

    task automatic test_reset_mid_stream();
        int dc, cons;
        set_nominal();
        build_items(1'b1);
        run_seq(0, 27 + 3 + 40, -1, dc, cons);
        build_items(1'b1);
        run_seq(0, -1, -1, dc, cons);
        check_consumed("replay", cons);
    endtask

    task automatic test_start_during_weight();
        int dc, cons;
        set_nominal();
        build_items(1'b1);
        run_seq(0, -1, 12, dc, cons);
        check_consumed("start_busy", cons);
    endtask

    task automatic test_random();
        int dc, cons;
        for (int r = 0; r < 5; r++) begin
            c_fw = 8'($urandom_range(1, 4));
            c_fs = 8'($urandom_range(1, 4));
            c_nf = 8'($urandom_range(1, 3));
            c_pw = 8'($urandom_range(0, 255));
            c_ph = 8'($urandom_range(0, 255));
            c_slen = 16'(c_fw) + 16'($urandom_range(1, 20));
            c_drain = 8'($urandom_range(0, 3));
            build_items(1'b1);
            run_seq(2, -1, -1, dc, cons);
            check_consumed("random", cons);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_cfg_reject();
        test_drain_zero();
        test_reset_mid_stream();
        test_start_during_weight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
